// File: rtl/data_memory_responder_if.sv
// Memory-side handshake bundle between the cache controller and the
// main-memory responder.
interface data_memory_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0]   address;
    logic                mem_read;
    logic                mem_write;
    logic [DATA_W-1:0]   write_data;
    logic                ready;
    logic [4*DATA_W-1:0] block_out;
    logic                proto_err;

    modport master (
        output address, mem_read, mem_write, write_data,
        input  ready, block_out, proto_err
    );

    modport slave (
        input  address, mem_read, mem_write, write_data,
        output ready, block_out, proto_err
    );
endinterface

// File: rtl/data_memory_responder.sv
// Fixed-latency main-memory responder. It serves 4-word block reads for
// miss fills and single-word write-throughs, and it owns the word array.
module data_memory_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    data_memory_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY, RESP} state_t;

    localparam logic [3:0] LAST = 4'(LATENCY - 1);

    state_t              state;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [4*DATA_W-1:0] hold_buf;
    logic [4*DATA_W-1:0] next_buf;
    logic [4*DATA_W-1:0] block_q;
    logic                ready_q;
    logic                proto_q;
    logic [ADDR_W-1:0]   rd_addr;
    logic                mem_we;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    // The fetch for counter value k lands straight in next_buf, so the last
    // word can reach block_out on the same edge that completes the read.
    always_comb begin
        next_buf = hold_buf;
        rd_addr  = {addr[ADDR_W-1:2], cnt[1:0]};
        if (state == RD_BUSY && cnt < 4'd4)
            next_buf[DATA_W*cnt[1:0] +: DATA_W] = mem[rd_addr];
    end

    assign mem_we = (state == WR_BUSY) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[addr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            addr     <= '0;
            wdata    <= '0;
            hold_buf <= '0;
            block_q  <= '0;
            ready_q  <= 1'b0;
            proto_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.mem_read) begin
                        addr  <= {bus.address[ADDR_W-1:2], 2'b00};
                        state <= RD_BUSY;
                        if (bus.mem_write)
                            proto_q <= 1'b1;
                    end else if (bus.mem_write) begin
                        addr  <= bus.address;
                        wdata <= bus.write_data;
                        state <= WR_BUSY;
                    end
                end
                RD_BUSY: begin
                    hold_buf <= next_buf;
                    cnt      <= cnt + 4'd1;
                    if (cnt == LAST) begin
                        block_q <= next_buf;
                        ready_q <= 1'b1;
                        state   <= RESP;
                    end
                end
                WR_BUSY: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST) begin
                        ready_q <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    ready_q <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.block_out = block_q;
    assign bus.proto_err = proto_q;
endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Main-memory responder on the memory side of the cache controller's MemRead/MemWrite/Ready handshake. It services one request at a time after a fixed latency:
- **Block read (miss fill):** gathers four consecutive words into a block register and pulses Ready, so the controller can assert Fill in that cycle.
- **Single-word write-through:** commits one word and pulses Ready.

It sits between the cache controller and the backing word array, and owns that array.

## Interface
Parameters:
- DATA_W, 32, word width in bits
- ADDR_W, 10, word-address width; array depth 2^ADDR_W words
- LATENCY, 4, clock edges from request capture to Ready rise; legal range 4..15

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- Address  in  ADDR_W  word address from CPU; [1:0] = word offset in 4-word block
- MemRead  in  1  block-read request, level, held until Ready
- MemWrite  in  1  word-write request, level, held until Ready
- WriteData  in  DATA_W  word to store on write
- Ready  out  1  registered one-cycle completion pulse
- BlockOut  out  4*DATA_W  registered read block; word i at [DATA_W*i +: DATA_W]
- ProtoErr  out  1  sticky: MemRead and MemWrite both seen high in IDLE

## Operation
- **States:**
  - IDLE: no transaction.
  - RD_BUSY: block read in progress.
  - WR_BUSY: word write in progress.
  - RESP: Ready high.
- **Counter:** cnt, 4 bits. Cleared on capture; +1 per edge in the BUSY states.
- **IDLE:**
  - MemRead=1: capture base = {Address[ADDR_W-1:2],2'b00}, go RD_BUSY.
  - Else MemWrite=1: capture Address and WriteData, go WR_BUSY.
  - Both high: read wins and ProtoErr is set to 1 (stays 1 until reset).
- **RD_BUSY:**
  - At edges with cnt=k (k=0..3), load mem[base+k] into a holding buffer word k.
  - base+k never wraps, because base is block-aligned.
  - At the edge where cnt=LATENCY-1: copy the buffer to BlockOut, set Ready=1, go RESP.
- **WR_BUSY:** at the edge where cnt=LATENCY-1, write mem[addr]=wdata, set Ready=1, go RESP.
- **RESP:** next edge clears Ready and returns to IDLE. Requests are ignored during RESP, so a new request is captured no earlier than the edge after Ready falls.
- **Request drop mid-transaction:** the captured transaction still completes and Ready still pulses. Inputs sampled after capture are ignored.
- **BlockOut:** holds its value until the next read completes. Writes never change BlockOut, even to a word of the last-read block.
- **Reset (any time, including mid-transaction):**
  - State goes to IDLE, cnt=0, Ready=0, BlockOut=0, ProtoErr=0.
  - A pending write is abandoned, with no array update.
  - Array contents are not reset.

## Timing
- Capture edge is E0 (IDLE with a request high).
- Ready is high from E(LATENCY) to E(LATENCY+1), exactly one cycle.
  - LATENCY=4: a request seen at E0 gives Ready at E4. The controller sees Ready at E4..E5 and returns to IDLE at E5, when Ready falls.
- Read data:
  - Words are fetched at E1..E4.
  - BlockOut is valid coincident with Ready and stays stable afterwards.
- Write data is visible to a subsequent read captured at or after E(LATENCY+1).
- Back-to-back throughput: one transaction per LATENCY+2 cycles (capture, busy, RESP, IDLE).
- No combinational path from any input to any output.

## Test plan
- **Reset:** preload mem[i]=i, assert RST=0 for 2 cycles, release.
  - Required: Ready=0, BlockOut=0, ProtoErr=0.
  - Required: an idle wait of 10 cycles produces no Ready.
- **Block read, unaligned address:** MemRead=1, Address=0x0B3, preloaded mem[i]=i.
  - Required: Ready pulses exactly 4 edges after capture, for 1 cycle.
  - Required: BlockOut = {0xB3,0xB2,0xB1,0xB0}, held after Ready falls.
- **Write, then read-back:** MemWrite=1, Address=0x3FE, WriteData=0xDEADBEEF.
  - Required: Ready after 4 edges.
  - Then MemRead at 0x3FC: BlockOut word 2 = 0xDEADBEEF, BlockOut word 3 = 0x3FF.
- **Request drop and conflict:**
  - Assert MemRead for 1 cycle only. Required: Ready still pulses at E4.
  - Assert MemRead and MemWrite together. Required: a read is performed, ProtoErr=1 until reset.
- **Reset mid-write:** MemWrite to 0x010 with 0x12345678, assert RST low at E2.
  - Required: no Ready pulse.
  - Required: mem[0x10] is still 0x10 (checked by a later read).
- **Controller co-simulation:** cache controller plus this block, read miss then read hit at 0x085.
  - Required: Fill asserted in the Ready cycle.
  - Required: the Stall span is 5 cycles.
  - Required: no request re-issue in the RESP cycle.
